mult_seq_ctrl: RTL and testbench

- Control FSM for the team's shift-add multiplier datapath: multiplier shift register, multiplicand left-shift register and product accumulator.
- Accepts a start request and loads operands.
- Steps WIDTH iterations, issuing accumulate and shift strobes based on the multiplier LSB, then signals completion.
- Sits between the issuing unit and the datapath registers; owns no arithmetic itself.

---
 rtl/mult_seq_ctrl_if.sv | 28 ++
 rtl/mult_seq_ctrl.sv | 81 ++++++++
 tb/tb_mult_seq_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Start/strobe bundle between the issuing unit (master) and the shift-add
// multiply sequencer (slave), including the datapath control strobes.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             start;
    logic             lsb;
    logic             mplier_zero;
    logic             load;
    logic             clear_prod;
    logic             prod_we;
    logic             shift;
    logic             ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output start, lsb, mplier_zero,
        input  load, clear_prod, prod_we, shift, ready, busy, done, iter_cnt
    );

    modport slave (
        input  start, lsb, mplier_zero,
        output load, clear_prod, prod_we, shift, ready, busy, done, iter_cnt
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier: LOAD, WIDTH ITER steps, one-cycle DONE.
// Optional MULT_EARLY_EXIT_EN ends ITER as soon as the multiplier register is zero.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    mult_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_iter;
    logic             early_exit;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_EARLY_EXIT_EN
    // Remaining multiplier bits are zero, so skipping them cannot change the product.
    assign early_exit = (state == ITER) && bus.mplier_zero;
`else
    logic unused_mplier_zero;
    assign unused_mplier_zero = bus.mplier_zero;
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bus.load       = 1'b0;
        bus.clear_prod = 1'b0;
        bus.prod_we    = 1'b0;
        bus.shift      = 1'b0;
        bus.ready      = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
                bus.load       = 1'b1;
                bus.clear_prod = 1'b1;
                bus.busy       = 1'b1;
                cnt_nxt        = '0;
                state_nxt      = ITER;
            end
            ITER: begin
                bus.busy = 1'b1;
                if (early_exit) begin
                    state_nxt = DONE;
                end else begin
                    bus.shift   = 1'b1;
                    bus.prod_we = bus.lsb;
                    cnt_nxt     = cnt + 1'b1;
                    if (last_iter) state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.iter_cnt = cnt;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl (WIDTH=32) with a small multiplier-register model.
module tb_mult_seq_ctrl;
    localparam int W = 32;
    // output vector bit order: load clear_prod prod_we shift ready busy done
    localparam logic [6:0] O_LOAD = 7'b1100010;
    localparam logic [6:0] O_ITER = 7'b0001010;
    localparam logic [6:0] O_PW   = 7'b0010000;
    localparam logic [6:0] O_IDLE = 7'b0000100;
    localparam logic [6:0] O_DONE = 7'b0000001;

    logic clk, reset;
    logic [W-1:0] mreg, op;
    logic rnd_mode, rnd_lsb;
    logic [6:0] outs, exp_o;
    int nvec, nerr;

    mult_seq_ctrl_if #(.WIDTH(W)) bus ();
    mult_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Multiplier shift register as the datapath would hold it.
    always @(posedge clk) begin
        if (bus.load)       mreg <= op;
        else if (bus.shift) mreg <= mreg >> 1;
    end
    assign bus.lsb         = rnd_mode ? rnd_lsb : mreg[0];
    assign bus.mplier_zero = rnd_mode ? 1'b0 : (mreg == '0);
    assign outs = {bus.load, bus.clear_prod, bus.prod_we, bus.shift,
                   bus.ready, bus.busy, bus.done};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Start high across one edge; returns at the negedge of cycle 1.
    task automatic kick();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (!bus.done && c < 60) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c, n, d1, d2, rcnt, r1, loads, dones;
        logic prev_done;
        logic [4:0] viol;
        clk = 1'b0; reset = 1'b1; bus.start = 1'b0;
        rnd_mode = 1'b0; rnd_lsb = 1'b0; op = '0;
        nvec = 0; nerr = 0;
        repeat (2) @(negedge clk);
        chk("rst_outs", outs, O_IDLE);
        chk("rst_cnt", bus.iter_cnt, 0);
        reset = 1'b0;

        // multiplier 0xB: prod_we in cycles 2, 3, 5
        op = 32'h0000000B;
        kick();
        for (int cy = 1; cy <= 35; cy++) begin
            if (cy == 1)       exp_o = O_LOAD;
            else if (cy <= 33) exp_o = O_ITER | ((cy == 2 || cy == 3 || cy == 5) ? O_PW : 7'b0);
            else if (cy == 34) exp_o = O_DONE;
            else               exp_o = O_IDLE;
            chk($sformatf("t1_c%0d", cy), outs, exp_o);
            if (cy == 34) chk("t1_iter_cnt", bus.iter_cnt, W);
            @(negedge clk);
        end

        // start held high: done at 34 and 69, ready only at 35 between them
        bus.start = 1'b1;
        n = 0; d1 = 0; d2 = 0; rcnt = 0; r1 = 0;
        for (int cy = 1; cy <= 80; cy++) begin
            @(negedge clk);
            if (bus.done) begin
                if (n == 0) d1 = cy;
                else if (n == 1) d2 = cy;
                n++;
            end
            if (bus.ready && cy <= 68) begin
                rcnt++;
                r1 = cy;
            end
        end
        bus.start = 1'b0;
        chk("t2_done1", d1, 34);
        chk("t2_done2", d2, 69);
        chk("t2_ndone", n, 2);
        chk("t2_nready", rcnt, 1);
        chk("t2_ready_cyc", r1, 35);
        for (int k = 0; k < 60 && !bus.ready; k++) @(negedge clk);
        chk("t2_flush", bus.ready, 1);

        // asynchronous reset in cycle 15 of a run
        op = 32'h0000000B;
        kick();
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t3_rst_outs", outs, O_IDLE);
        chk("t3_rst_cnt", bus.iter_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("t3_no_done", dones, 0);
        kick();
        wait_done(c);
        chk("t3_restart_done", c, 34);
        @(negedge clk);

        // start pulses in cycles 5 and 20 are ignored
        kick();
        loads = 0; dones = 0; d1 = 0;
        for (int cy = 1; cy <= 40; cy++) begin
            if (bus.load) loads++;
            if (bus.done) begin dones++; d1 = cy; end
            bus.start = (cy == 5 || cy == 20);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("t4_loads", loads, 1);
        chk("t4_dones", dones, 1);
        chk("t4_done_cyc", d1, 34);

        // multiplier 0x5 with mplier_zero modelled
        op = 32'h00000005;
        kick();
        wait_done(c);
`ifdef MULT_EARLY_EXIT_EN
        chk("t5_done_cyc", c, 6);
        chk("t5_iter_cnt", bus.iter_cnt, 3);
        @(negedge clk);
        op = '0;
        kick();
        wait_done(c);
        chk("t5_zero_done_cyc", c, 3);
        chk("t5_zero_iter_cnt", bus.iter_cnt, 0);
`else
        chk("t5_done_cyc", c, 34);
        chk("t5_iter_cnt", bus.iter_cnt, W);
`endif
        @(negedge clk);

        // random start/lsb: structural properties every cycle
        rnd_mode = 1'b1;
        prev_done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            bus.start = 1'($urandom_range(0, 1));
            rnd_lsb   = 1'($urandom_range(0, 1));
            @(negedge clk);
            viol = {bus.shift & (bus.load | bus.clear_prod),
                    bus.load ^ bus.clear_prod,
                    bus.prod_we & ~(bus.busy & ~bus.load),
                    bus.done & prev_done,
                    (bus.iter_cnt > W) ? 1'b1 : 1'b0};
            chk($sformatf("t6_props_%0d", k), viol, 0);
            prev_done = bus.done;
        end
        bus.start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
